// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcode, phase and control-bundle definitions for cpu_ctrl
//
// Package cpu_pkg: opcode width, opcode constants OP_HLT..OP_JMP, phase
// constants S0..S7, the packed control bundle and an ALU-class helper.
package cpu_pkg;

    localparam int OP_W = 3;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;
    localparam logic [2:0] S7 = 3'd7;

    // Bit order matches the output register concatenation in cpu_ctrl.
    typedef struct packed {
        logic halt;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic load_ir;
        logic rd;
        logic wr;
        logic datactl_ena;
    } ctrl_t;

    function automatic logic is_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// rtl/cpu_ctrl_decode.sv - combinational phase/opcode decode into datapath controls
//
// Ports:
//   next_state  in  3  phase the controls are being prepared for
//   opcode      in  3  instruction opcode
//   zero        in  1  accumulator-is-zero flag
//   ctrl        out    decoded control bundle (ctrl_t)
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [2:0] next_state,
    input  logic [2:0] opcode,
    input  logic       zero,
    output ctrl_t      ctrl
);

    logic alu;
    logic skip;

    always_comb begin
        ctrl = '0;
        alu  = is_alu(opcode);
        skip = (opcode == OP_SKZ) && zero;
        case (next_state)
            S0, S1: begin
                ctrl.rd      = 1'b1;
                ctrl.load_ir = 1'b1;
                ctrl.inc_pc  = 1'b1;
            end
            S3: begin
                // An unknown opcode falls to the inc_pc branch, so the FSM never stalls.
                if (opcode == OP_HLT) ctrl.halt   = 1'b1;
                else                  ctrl.inc_pc = 1'b1;
            end
            S4: begin
                if (alu)                    ctrl.rd          = 1'b1;
                else if (opcode == OP_STO)  ctrl.datactl_ena = 1'b1;
                else if (opcode == OP_JMP)  ctrl.load_pc     = 1'b1;
            end
            S5: begin
                if (alu) begin
                    ctrl.rd       = 1'b1;
                    ctrl.load_acc = 1'b1;
                end else if (opcode == OP_STO) begin
                    ctrl.datactl_ena = 1'b1;
                    ctrl.wr          = 1'b1;
                end else if (opcode == OP_JMP) begin
                    ctrl.load_pc = 1'b1;
                end else if (skip) begin
                    ctrl.inc_pc = 1'b1;
                end
            end
            S6: begin
                if (opcode == OP_STO) ctrl.datactl_ena = 1'b1;
            end
            S7: begin
                if (skip) ctrl.inc_pc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - eight-phase CPU sequencer with registered datapath controls
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   fetch              fetch-phase strobe; first high sample enables the sequencer
//   opcode [OP_W]      instruction opcode
//   zero               accumulator-is-zero flag
//   inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena   registered controls
//   halt               sticky halt
//   state [3]          current phase S0..S7
module cpu_ctrl #(
    parameter int OP_W = cpu_pkg::OP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            inc_pc,
    output logic            load_pc,
    output logic            load_acc,
    output logic            load_ir,
    output logic            rd,
    output logic            wr,
    output logic            datactl_ena,
    output logic            halt,
    output logic [2:0]      state
);
    import cpu_pkg::*;

    logic       ena;
    logic       ena_next;
    logic [2:0] next_state;
    ctrl_t      dec;

    assign ena_next = ena | fetch;

    // The enabling edge itself keeps state at S0 but already loads the S0
    // controls, so the first cycle with ena set is a full S0.
    assign next_state = (ena && !halt) ? state + 3'd1 : state;

    cpu_ctrl_decode u_decode (
        .next_state (next_state),
        .opcode     (opcode),
        .zero       (zero),
        .ctrl       (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena         <= 1'b0;
            state       <= S0;
            halt        <= 1'b0;
            inc_pc      <= 1'b0;
            load_pc     <= 1'b0;
            load_acc    <= 1'b0;
            load_ir     <= 1'b0;
            rd          <= 1'b0;
            wr          <= 1'b0;
            datactl_ena <= 1'b0;
        end else if (!halt) begin
            // Once halted, everything freezes: state at S3, halt high, the
            // remaining controls already low from the S3 HLT decode.
            ena   <= ena_next;
            state <= next_state;
            {halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena}
                <= ena_next ? dec : ctrl_t'('0);
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - self-checking bench for cpu_ctrl
module tb_cpu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch;
    logic [2:0] opcode;
    logic       zero;
    logic       inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt;
    logic [2:0] state;
    logic [7:0] dctrl;

    int checks = 0;
    int errors = 0;

    // Reference model: instruction phase counter plus enable/halt flags.
    bit         m_ena;
    bit         m_halt;
    int         m_phase;
    logic [7:0] m_ctrl;

    cpu_ctrl #(.OP_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch       (fetch),
        .opcode      (opcode),
        .zero        (zero),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_acc    (load_acc),
        .load_ir     (load_ir),
        .rd          (rd),
        .wr          (wr),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .state       (state)
    );

    always #5 clk = ~clk;

    // {halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena}
    assign dctrl = {halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena};

    function automatic logic [7:0] rules(input int ph, input int op, input bit z);
        bit alu;
        bit skz;
        logic [7:0] r;
        alu = (op >= 2) && (op <= 5);
        skz = (op == 1) && z;
        r = 8'h00;
        if (ph <= 1)       r = 8'h4C;
        else if (ph == 3)  r = (op == 0) ? 8'h80 : 8'h40;
        else if (ph == 4)  r = alu ? 8'h04 : (op == 6) ? 8'h01 : (op == 7) ? 8'h20 : 8'h00;
        else if (ph == 5)  r = alu ? 8'h14 : (op == 6) ? 8'h03 : (op == 7) ? 8'h20 : skz ? 8'h40 : 8'h00;
        else if (ph == 6)  r = (op == 6) ? 8'h01 : 8'h00;
        else if (ph == 7)  r = skz ? 8'h40 : 8'h00;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ena   = 1'b0;
        m_halt  = 1'b0;
        m_phase = 0;
        m_ctrl  = 8'h00;
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic tick();
        bit ne;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!m_halt) begin
            ne = m_ena | fetch;
            if (m_ena) m_phase = (m_phase + 1) % 8;
            m_ctrl = ne ? rules(m_phase, int'(opcode), zero) : 8'h00;
            m_halt = m_ctrl[7];
            m_ena  = ne;
        end
        @(negedge clk);
        check("ctrl", dctrl, m_ctrl);
        check("state", {5'd0, state}, 8'(m_phase));
        checks++;
        if ((rd && wr) || (load_pc && inc_pc)) begin
            errors++;
            $display("FAIL exclusive: rd=%b wr=%b load_pc=%b inc_pc=%b", rd, wr, load_pc, inc_pc);
        end
    endtask

    task automatic enable_seq();
        fetch = 1'b0;
        repeat (3) tick();
        fetch = 1'b1;
        tick();
        check("enable_s0_state", {5'd0, state}, 8'h00);
        check("enable_s0_ctrl", dctrl, 8'h4C);
        fetch = 1'b0;
    endtask

    typedef struct {
        logic [2:0]       op;
        bit               z;
        logic [0:7][7:0]  exp;
        string            name;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{3'd5, 1'b0, {8'h4C, 8'h4C, 8'h00, 8'h40, 8'h04, 8'h14, 8'h00, 8'h00}, "LDA"};
        tbl[1] = '{3'd2, 1'b1, {8'h4C, 8'h4C, 8'h00, 8'h40, 8'h04, 8'h14, 8'h00, 8'h00}, "ADD"};
        tbl[2] = '{3'd3, 1'b0, {8'h4C, 8'h4C, 8'h00, 8'h40, 8'h04, 8'h14, 8'h00, 8'h00}, "AND"};
        tbl[3] = '{3'd4, 1'b1, {8'h4C, 8'h4C, 8'h00, 8'h40, 8'h04, 8'h14, 8'h00, 8'h00}, "XOR"};
        tbl[4] = '{3'd6, 1'b0, {8'h4C, 8'h4C, 8'h00, 8'h40, 8'h01, 8'h03, 8'h01, 8'h00}, "STO"};
        tbl[5] = '{3'd7, 1'b1, {8'h4C, 8'h4C, 8'h00, 8'h40, 8'h20, 8'h20, 8'h00, 8'h00}, "JMP"};
        tbl[6] = '{3'd1, 1'b1, {8'h4C, 8'h4C, 8'h00, 8'h40, 8'h00, 8'h40, 8'h00, 8'h40}, "SKZ_z1"};
        tbl[7] = '{3'd1, 1'b0, {8'h4C, 8'h4C, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00}, "SKZ_z0"};

        rst = 1'b1; fetch = 1'b0; zero = 1'b0; opcode = 3'd5;
        model_reset();
        #2;
        check("reset_ctrl", dctrl, 8'h00);
        check("reset_state", {5'd0, state}, 8'h00);
        @(negedge clk);
        tick();
        rst = 1'b0;
        enable_seq();

        // Table: one full instruction per entry, starting at S0.
        for (int i = 0; i < 8; i++) begin
            opcode = tbl[i].op;
            zero   = tbl[i].z;
            check({tbl[i].name, "_p0"}, dctrl, tbl[i].exp[0]);
            for (int p = 1; p < 8; p++) begin
                tick();
                check({tbl[i].name, "_p", $sformatf("%0d", p)}, dctrl, tbl[i].exp[p]);
            end
            tick();
        end

        // Reset in S5 of ADD aborts immediately; restart only after fetch.
        opcode = 3'd2;
        repeat (5) tick();
        check("add_s5_ctrl", dctrl, 8'h14);
        rst = 1'b1;
        #1;
        model_reset();
        check("midreset_ctrl", dctrl, 8'h00);
        check("midreset_state", {5'd0, state}, 8'h00);
        @(negedge clk);
        tick();
        rst = 1'b0;
        enable_seq();
        tick();
        check("restart_s1_state", {5'd0, state}, 8'h01);
        repeat (7) tick();

        // HLT: halt from S3, frozen for 20 clocks while fetch toggles.
        opcode = 3'd0;
        repeat (3) tick();
        check("hlt_s3_ctrl", dctrl, 8'h80);
        for (int k = 0; k < 20; k++) begin
            fetch = ~fetch;
            tick();
        end
        check("hlt_frozen_state", {5'd0, state}, 8'h03);
        check("hlt_frozen_ctrl", dctrl, 8'h80);
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        enable_seq();

        // Random instructions against the model.
        for (int n = 0; n < 1000; n++) begin
            opcode = 3'($urandom_range(1, 7));
            for (int p = 0; p < 8; p++) begin
                zero  = 1'($urandom);
                fetch = 1'($urandom);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
